fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/stream_skid_buf.sv | 75 +++++++
 rtl/fifo_rd_stream.sv | 165 ++++++++++++++++
 tb/tb_fifo_rd_stream.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO read-stream block:
//   - BUF_DEPTH : depth of the output buffer; also the cap on words that
//                 may be read from the FIFO but not yet delivered downstream
//   - BUF_PTR_W : pointer width for the output buffer
//   - BUF_CNT_W : counter width able to hold 0..BUF_DEPTH
//   - rd_state_e: burst controller state encoding
//   - cnt_step  : up/down step shared by the credit counter and the buffer
//                 occupancy counter
package fifo_pkg;

  localparam int BUF_DEPTH = 4;
  localparam int BUF_PTR_W = $clog2(BUF_DEPTH);
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // Simultaneous increment and decrement cancel out.
  function automatic logic [BUF_CNT_W-1:0] cnt_step(
    input logic [BUF_CNT_W-1:0] cur,
    input logic                 inc,
    input logic                 dec
  );
    logic [BUF_CNT_W-1:0] nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + BUF_CNT_W'(1);
      2'b01:   nxt = cur - BUF_CNT_W'(1);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf
// Small circular buffer between the FIFO read pipeline and the output
// stream. Each entry carries the data word plus its last flag. The head
// entry is presented combinationally, so it stays stable until popped.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : WIDTH-bit entry to store
//   pop        : consume the head entry (ignored when empty)
//   out_valid  : buffer holds at least one entry
//   out_data   : head entry, zero while empty
//   count      : current occupancy 0..BUF_DEPTH
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [BUF_CNT_W-1:0] count
);

  logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
  logic [WIDTH-1:0]     mem_d [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0] count_q, count_d;
  logic                 do_push;
  logic                 do_pop;

  // The controller's credit limit keeps push off a full buffer; the guard
  // here only protects the contents should that ever be violated.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != BUF_CNT_W'(BUF_DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + BUF_PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + BUF_PTR_W'(1);
    end
    count_d = cnt_step(count_q, do_push, do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Reads a burst of burst_len words from a synchronous FIFO with a fixed
// read latency and forwards them as a valid/ready stream, flagging the
// final word with m_last. At most BUF_DEPTH words are ever outstanding
// (read but not yet accepted downstream), so the output buffer can never
// overflow no matter how long m_ready stays low.
// Parameters:
//   DATA_WIDTH : FIFO read-data and stream width
//   RD_LAT     : FIFO read latency in cycles; only 1 or 2 are legal
//   LEN_WIDTH  : burst length width
// Ports:
//   rd_clk, rd_rst          : clock, asynchronous active-high reset
//   start, burst_len        : burst request pulse and its length (IDLE only)
//   busy, done              : burst in progress, one-cycle completion pulse
//   fifo_rd_en, fifo_empty,
//   fifo_rd_data            : FIFO read side
//   m_data, m_valid,
//   m_ready, m_last         : output stream
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RD_LAT     = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  rd_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [BUF_CNT_W-1:0]  credits_q, credits_d;
  logic [RD_LAT-1:0]     vld_sr_q, vld_sr_d;
  logic [RD_LAT-1:0]     last_sr_q, last_sr_d;
  logic                  busy_q;
  logic                  done_q;

  logic                  pop;
  logic                  issue_last;
  logic                  cap_valid;
  logic                  cap_last;
  logic                  drained;
  logic [BUF_CNT_W-1:0]  buf_count;
  logic [DATA_WIDTH:0]   buf_out;

  assign fifo_rd_en = (state_q == ST_RUN) && !fifo_empty &&
                      (issued_q < len_q) &&
                      (credits_q < BUF_CNT_W'(BUF_DEPTH));

  assign pop = m_valid && m_ready;

  // The last flag is decided when the read is issued and travels with the
  // valid bit, so the buffer never has to count delivered words.
  assign issue_last = ((issued_q + LEN_WIDTH'(1)) == len_q);

  assign cap_valid = vld_sr_q[RD_LAT-1];
  assign cap_last  = last_sr_q[RD_LAT-1];

  // Looks one cycle ahead: if the only buffered word leaves this cycle the
  // burst is complete, so done follows the final handshake directly.
  assign drained = (vld_sr_q == '0) &&
                   ((buf_count == '0) ||
                    ((buf_count == BUF_CNT_W'(1)) && pop));

  always_comb begin
    vld_sr_d  = (vld_sr_q << 1) | RD_LAT'(fifo_rd_en);
    last_sr_d = (last_sr_q << 1) | RD_LAT'(fifo_rd_en && issue_last);
    credits_d = cnt_step(credits_q, fifo_rd_en, pop);
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = burst_len;
          issued_d = '0;
          state_d  = (burst_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (fifo_rd_en) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (issued_q == len_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (drained) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy and done are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      issued_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      busy_q   <= (state_d == ST_RUN) || (state_d == ST_FLUSH);
      done_q   <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      credits_q <= '0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
    end else begin
      credits_q <= credits_d;
      vld_sr_q  <= vld_sr_d;
      last_sr_q <= last_sr_d;
    end
  end

  stream_skid_buf #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (cap_valid),
    .push_data ({cap_last, fifo_rd_data}),
    .pop       (pop),
    .out_valid (m_valid),
    .out_data  (buf_out),
    .count     (buf_count)
  );

  assign m_data = buf_out[DATA_WIDTH-1:0];
  assign m_last = buf_out[DATA_WIDTH];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
// Drives two instances side by side (RD_LAT=1 and RD_LAT=2) from the same
// start/length/ready stimulus, each reading its own model FIFO loaded with
// identical words. Expected words are queued when a burst is requested and
// a negedge monitor pops them as the DUTs hand words over.
module tb_fifo_rd_stream;

  localparam int DW      = 16;
  localparam int LW      = 16;
  localparam int TIMEOUT = 400;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          m_ready;
  logic          force_empty;
  logic          fifo_clear;

  logic          busy_w    [2];
  logic          done_w    [2];
  logic          rd_en_w   [2];
  logic          empty_w   [2];
  logic          m_valid_w [2];
  logic          m_last_w  [2];
  logic [DW-1:0] rd_data_w [2];
  logic [DW-1:0] m_data_w  [2];

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  logic [DW-1:0] fifo_mem [0:4095];
  int            fifo_wr = 0;
  int            rd_ptr [2];
  int            rden_total [2];
  logic [DW-1:0] pipe1;

  logic [DW:0] exp_q0 [$];
  logic [DW:0] exp_q1 [$];

  int   burst_id    = 0;
  bit   zero_burst  = 1'b0;
  int   start_cycle = 0;

  int          seen_burst [2];
  int          rden_first [2];
  int          hs_first   [2];
  int          last_hs    [2];
  int          done_count [2];
  bit          valid_seen [2];
  bit          held_v     [2];
  logic [DW:0] held_word  [2];

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(1), .LEN_WIDTH(LW)) u_dut_lat1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .burst_len(burst_len),
    .busy(busy_w[0]), .done(done_w[0]), .fifo_rd_en(rd_en_w[0]),
    .fifo_empty(empty_w[0]), .fifo_rd_data(rd_data_w[0]), .m_data(m_data_w[0]),
    .m_valid(m_valid_w[0]), .m_ready(m_ready), .m_last(m_last_w[0])
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LAT(2), .LEN_WIDTH(LW)) u_dut_lat2 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .burst_len(burst_len),
    .busy(busy_w[1]), .done(done_w[1]), .fifo_rd_en(rd_en_w[1]),
    .fifo_empty(empty_w[1]), .fifo_rd_data(rd_data_w[1]), .m_data(m_data_w[1]),
    .m_valid(m_valid_w[1]), .m_ready(m_ready), .m_last(m_last_w[1])
  );

  assign empty_w[0] = force_empty || (rd_ptr[0] >= fifo_wr);
  assign empty_w[1] = force_empty || (rd_ptr[1] >= fifo_wr);

  function automatic void check(input string name, input int d,
                                input longint got, input longint req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("[TB] FAIL %s dut%0d: got %0d required %0d", name, d, got, req);
    end
  endfunction

  always @(posedge rd_clk) cycle <= cycle + 1;

  // Model FIFOs: RD_LAT=1 data appears the cycle after the read, RD_LAT=2
  // passes through one extra register.
  always @(posedge rd_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fifo_clear) begin
        rd_ptr[d] <= fifo_wr;
      end else if (rd_en_w[d]) begin
        check("rd_en_while_empty", d, empty_w[d], 0);
        rden_total[d] = rden_total[d] + 1;
        rd_ptr[d] <= rd_ptr[d] + 1;
      end
    end
    if (rd_en_w[0] && !fifo_clear) rd_data_w[0] <= fifo_mem[rd_ptr[0]];
    if (rd_en_w[1] && !fifo_clear) pipe1 <= fifo_mem[rd_ptr[1]];
    rd_data_w[1] <= pipe1;
  end

  task automatic checkOutput(input int d);
    logic [DW:0] got;
    logic [DW:0] req;
    bit          have;
    if (seen_burst[d] != burst_id) begin
      seen_burst[d] = burst_id;
      rden_first[d] = -1;
      hs_first[d]   = -1;
      valid_seen[d] = 1'b0;
    end
    if (rd_rst) begin
      held_v[d] = 1'b0;
      return;
    end
    got = {m_last_w[d], m_data_w[d]};
    if (rd_en_w[d] && rden_first[d] < 0) rden_first[d] = cycle;
    if (held_v[d]) check("hold_stable", d, {m_valid_w[d], got}, {1'b1, held_word[d]});
    if (m_valid_w[d] && !valid_seen[d]) begin
      valid_seen[d] = 1'b1;
      check("first_valid_latency", d, cycle - rden_first[d], d + 2);
    end
    if (m_valid_w[d] && m_ready) begin
      have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (!have) begin
        check("unexpected_word", d, got, -1);
      end else begin
        req = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check("stream_word", d, got, req);
      end
      if (hs_first[d] < 0) hs_first[d] = cycle;
      last_hs[d] = cycle;
    end
    held_v[d]    = m_valid_w[d] && !m_ready;
    held_word[d] = got;
    if (done_w[d]) begin
      done_count[d]++;
      if (zero_burst) check("done_after_start", d, cycle - start_cycle, 1);
      else            check("done_after_last_hs", d, cycle - last_hs[d], 1);
    end
  endtask

  always @(negedge rd_clk) begin
    for (int d = 0; d < 2; d++) checkOutput(d);
  end

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  // Loads len words into both model FIFOs, queues the expected stream and
  // pulses start.
  task automatic applyStimulus(input int len, input bit seq_data);
    logic [DW-1:0] w;
    for (int i = 0; i < len; i++) begin
      w = seq_data ? DW'(i + 1) : DW'($urandom_range(0, 65535));
      fifo_mem[fifo_wr + i] = w;
      exp_q0.push_back({(i == len - 1), w});
      exp_q1.push_back({(i == len - 1), w});
    end
    fifo_wr     = fifo_wr + len;
    zero_burst  = (len == 0);
    start_cycle = cycle;
    burst_id++;
    burst_len = LW'(len);
    start     = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic waitDone(input int target, input bit rnd);
    int n;
    n = 0;
    while ((done_count[0] < target || done_count[1] < target) && n < TIMEOUT) begin
      if (rnd) begin
        m_ready     = ($urandom_range(0, 3) != 0);
        force_empty = ($urandom_range(0, 4) == 0);
      end
      step();
      n++;
    end
    m_ready     = 1'b1;
    force_empty = 1'b0;
    check("done_within_budget", 0, (n < TIMEOUT), 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_outputs"}, d,
            {busy_w[d], done_w[d], rd_en_w[d], m_valid_w[d], m_last_w[d], m_data_w[d]}, 0);
    end
  endtask

  initial begin
    int n_done;
    int base [2];
    n_done = 0;
    for (int d = 0; d < 2; d++) begin
      rd_ptr[d] = 0; rden_total[d] = 0; done_count[d] = 0; seen_burst[d] = 0;
      held_v[d] = 1'b0; last_hs[d] = 0; rden_first[d] = -1; hs_first[d] = -1;
      valid_seen[d] = 1'b0; held_word[d] = '0;
    end
    pipe1 = '0; rd_data_w[0] = '0; rd_data_w[1] = '0;
    rd_rst = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    force_empty = 1'b0; fifo_clear = 1'b0;
    repeat (3) step();
    rd_rst = 1'b0;
    step();
    checkIdleOutputs("reset");

    // 16 sequential words at full rate
    m_ready = 1'b1;
    for (int d = 0; d < 2; d++) base[d] = rden_total[d];
    applyStimulus(16, 1'b1);
    waitDone(++n_done, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check("rden_count_16", d, rden_total[d] - base[d], 16);
      check("handshake_span_16", d, last_hs[d] - hs_first[d], 15);
    end

    // downstream stalled after the first word appears
    m_ready = 1'b0;
    for (int d = 0; d < 2; d++) base[d] = rden_total[d];
    applyStimulus(8, 1'b1);
    repeat (14) step();
    for (int d = 0; d < 2; d++) begin
      check("stall_rden_le4", d, (rden_total[d] - base[d] <= 4), 1);
      check("stall_head_word", d, {m_valid_w[d], m_data_w[d]}, {1'b1, 16'd1});
    end
    m_ready = 1'b1;
    waitDone(++n_done, 1'b0);
    for (int d = 0; d < 2; d++) check("rden_count_8", d, rden_total[d] - base[d], 8);

    // random lengths, random back-pressure and FIFO empties
    for (int it = 0; it < 6; it++) begin
      applyStimulus($urandom_range(1, 20), 1'b0);
      waitDone(++n_done, 1'b1);
    end

    // zero-length burst
    for (int d = 0; d < 2; d++) base[d] = rden_total[d];
    applyStimulus(0, 1'b0);
    for (int d = 0; d < 2; d++) check("zero_len_state", d, {busy_w[d], done_w[d]}, 2'b01);
    waitDone(++n_done, 1'b0);
    for (int d = 0; d < 2; d++) check("zero_len_no_rden", d, rden_total[d] - base[d], 0);

    // start while busy must be ignored
    applyStimulus(6, 1'b1);
    repeat (2) step();
    burst_len = LW'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    waitDone(++n_done, 1'b0);
    repeat (6) step();
    for (int d = 0; d < 2; d++) begin
      check("busy_start_ignored_done", d, done_count[d], n_done);
      check("busy_start_ignored_busy", d, busy_w[d], 0);
    end

    // FIFO runs dry mid-burst, then reset aborts the burst
    applyStimulus(12, 1'b1);
    repeat (3) step();
    force_empty = 1'b1;
    for (int d = 0; d < 2; d++) base[d] = rden_total[d];
    repeat (5) step();
    for (int d = 0; d < 2; d++) check("empty_stall", d, rden_total[d] - base[d], 0);
    force_empty = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 2; d++) check("empty_resume", d, (rden_total[d] > base[d]), 1);
    rd_rst = 1'b1;
    fifo_clear = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    step();
    checkIdleOutputs("mid_reset");
    rd_rst = 1'b0;
    fifo_clear = 1'b0;
    for (int d = 0; d < 2; d++) base[d] = rden_total[d];
    repeat (10) step();
    checkIdleOutputs("post_reset");
    for (int d = 0; d < 2; d++) begin
      check("post_reset_no_done", d, done_count[d], n_done);
      check("post_reset_no_rden", d, rden_total[d] - base[d], 0);
    end

    // controller must be back in IDLE and accept a fresh burst
    applyStimulus(4, 1'b0);
    waitDone(++n_done, 1'b0);
    repeat (3) step();
    check("exp_left", 0, exp_q0.size(), 0);
    check("exp_left", 1, exp_q1.size(), 0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
